vliw_hazard_scoreboard: RTL and testbench
=========================================

Name: vliw_hazard_scoreboard

Overview:
Parametrised load-use and branch hazard controller for the multi-slot VLIW pipeline, sitting between the IF/ID register and ID/EX control mux.
- Keeps a per-register pending-load scoreboard, so load latency is configurable instead of fixed at one bubble.
- Checks every slot of the decoded bundle against the scoreboard.
- Turns a taken branch into a timed flush window instead of a stall.

Parameters:
NUM_SLOTS, 2, issue slots per bundle
REG_ADDR_W, 3, register address width; register file has 2**REG_ADDR_W entries
LOAD_LAT, 1, cycles after load issue before its result is forwardable (>=1)
BRANCH_BUBBLES, 1, cycles of IF/ID flush after a taken branch (>=1)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  IF/ID holds a valid bundle
id_rs1  in  NUM_SLOTS*REG_ADDR_W  source 1 per slot (slot 0 in LSBs)
id_rs2  in  NUM_SLOTS*REG_ADDR_W  source 2 per slot
id_rd  in  NUM_SLOTS*REG_ADDR_W  destination per slot
id_rs1_en  in  NUM_SLOTS  rs1 used
id_rs2_en  in  NUM_SLOTS  rs2 used
id_rd_en  in  NUM_SLOTS  rd written
id_is_load  in  NUM_SLOTS  slot is a load
branch_taken  in  1  taken branch resolved in EX this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID update enable
ctrl_mux  out  1  1 = pass decoded control, 0 = insert bubble
if_id_flush  out  1  clear IF/ID contents
bundle_conflict  out  1  sticky intra-bundle RAW/WAW error
stall_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
State:
- pend[r]: one per register, width clog2(LOAD_LAT+1).
- flush_cnt: width clog2(BRANCH_BUBBLES+1).
- bundle_conflict flop.
- stall_cycles counter.

Reset (async, all state cleared):
- pend = 0, flush_cnt = 0, bundle_conflict = 0, stall_cycles = 0.
- Outputs at reset: pc_write = 1, if_id_write = 1, ctrl_mux = 1, if_id_flush = 0.

Hazard detection:
- hit = id_valid and, for any slot, an enabled rs1, rs2 or rd has pend != 0. The rd check covers WAW.
- flushing = branch_taken or (flush_cnt != 0).
- stall = hit and not flushing.
- issue = id_valid and not stall and not flushing.

Outputs (combinational from current state and inputs):
- stall: pc_write = 0, if_id_write = 0, ctrl_mux = 0, if_id_flush = 0.
- flushing: pc_write = 1, if_id_write = 1, ctrl_mux = 0, if_id_flush = 1. Flush has priority over stall; the stalled bundle is discarded.
- otherwise: pc_write = 1, if_id_write = 1, ctrl_mux = 1, if_id_flush = 0.

Scoreboard update, per clock edge:
- Every nonzero pend[r] decrements by 1.
- Then, on issue, each slot with id_is_load and id_rd_en sets pend[id_rd] = LOAD_LAT. Set overrides decrement.
- Nothing is set while stall or flushing.
- LOAD_LAT = 1 gives exactly one bubble per load-use.

Flush counter:
- branch_taken loads flush_cnt = BRANCH_BUBBLES - 1. The branch cycle itself is the first flush cycle.
- Otherwise flush_cnt decrements while nonzero.
- branch_taken during an active window reloads the counter (window restarts).

bundle_conflict:
- Set when id_valid and some slot j > i reads (enabled rs1/rs2) or writes the enabled id_rd of slot i.
- Sticky until reset.
- Does not alter stall or flush.

stall_cycles:
- Increments on each cycle with stall = 1.
- Holds at all-ones (saturates).

Reset mid-operation clears pending loads and flush window immediately; first post-reset cycle sees no hazard.

Decomposition:
- Shared package vliw_pkg: REG_ADDR_W, NUM_SLOTS defaults, and slot-field extraction helper functions.
- One sub-module, hazard_sb_entry: a single pend counter with set/decrement/busy. Instantiated 2**REG_ADDR_W times via generate.
- Comparison trees and flush/stall logic live in the top.

Test Plan:
1. LOAD_LAT=1: slot0 load r3 issues; next bundle slot1 reads r3 -> one cycle pc_write=0, if_id_write=0, ctrl_mux=0; issues on the following cycle; stall_cycles = 1.
2. LOAD_LAT=3: load r5, dependent reader next -> exactly 3 stall cycles. A reader of unrelated r2 in the same position -> 0 stalls.
3. BRANCH_BUBBLES=2: branch_taken pulse -> if_id_flush=1, ctrl_mux=0 for 2 cycles, pc_write=1 throughout. Second branch_taken in cycle 2 -> window extends to cycle 3.
4. Pending load hazard present while branch_taken=1 -> flush outputs, no stall, stall_cycles unchanged, no scoreboard set from the discarded bundle.
5. Bundle with slot0 rd=r4 and slot1 rs2=r4 enabled -> bundle_conflict=1 and stays 1 until rst; no stall is caused.
6. Assert rst while pend[r3]=2 and flush_cnt=1 -> outputs return to reset values immediately; a reader of r3 after reset sees no stall.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared defaults and slot-field helpers for the VLIW hazard
// scoreboard and its per-register pending-load entries.
package vliw_pkg;

  localparam int DEF_NUM_SLOTS  = 2;
  localparam int DEF_REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_STALL,
    MODE_FLUSH
  } mode_e;

  function automatic int fld_lo(
    input int slot,
    input int w
  );
    return slot * w;
  endfunction

endpackage

// File: rtl/vliw_hazard_scoreboard_entry.sv
// One pending-load counter: set to LOAD_LAT on issue, then counts
// down to zero; busy while nonzero.
module hazard_sb_entry #(
  parameter int LOAD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_set,
  output logic o_busy
);

  localparam int PW = $clog2(LOAD_LAT + 1);

  logic [PW-1:0] r_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else if (i_set) begin
      r_pend <= PW'(LOAD_LAT);
    end else if (r_pend != '0) begin
      r_pend <= r_pend - PW'(1);
    end
  end

  assign o_busy = (r_pend != '0);

endmodule

// File: rtl/vliw_hazard_scoreboard.sv
// Load-use / WAW / branch hazard control for the multi-slot VLIW
// pipeline, between the IF/ID register and the ID/EX control mux.
module vliw_hazard_scoreboard
  import vliw_pkg::*;
#(
  parameter int NUM_SLOTS      = DEF_NUM_SLOTS,
  parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
  parameter int LOAD_LAT       = 1,
  parameter int BRANCH_BUBBLES = 1,
  parameter int CNT_W          = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] id_rs1,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] id_rs2,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] id_rd,
  input  logic [NUM_SLOTS-1:0]            id_rs1_en,
  input  logic [NUM_SLOTS-1:0]            id_rs2_en,
  input  logic [NUM_SLOTS-1:0]            id_rd_en,
  input  logic [NUM_SLOTS-1:0]            id_is_load,
  input  logic                            branch_taken,
  output logic                            pc_write,
  output logic                            if_id_write,
  output logic                            ctrl_mux,
  output logic                            if_id_flush,
  output logic                            bundle_conflict,
  output logic [CNT_W-1:0]                stall_cycles
);

  localparam int NREG = 2 ** REG_ADDR_W;
  localparam int FW   = $clog2(BRANCH_BUBBLES + 1);

  logic [REG_ADDR_W-1:0] w_rs1 [NUM_SLOTS];
  logic [REG_ADDR_W-1:0] w_rs2 [NUM_SLOTS];
  logic [REG_ADDR_W-1:0] w_rd  [NUM_SLOTS];
  logic [NREG-1:0]       w_busy;
  logic [NREG-1:0]       w_set;
  logic                  w_hit;
  logic                  w_conflict;
  logic                  w_flushing;
  logic                  w_stall;
  logic                  w_issue;
  mode_e                 w_mode;
  logic [FW-1:0]         r_flush_cnt;
  logic                  r_conflict;
  logic [CNT_W-1:0]      r_stall_cnt;

  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      w_rs1[s] = id_rs1[fld_lo(s, REG_ADDR_W) +: REG_ADDR_W];
      w_rs2[s] = id_rs2[fld_lo(s, REG_ADDR_W) +: REG_ADDR_W];
      w_rd[s]  = id_rd[fld_lo(s, REG_ADDR_W) +: REG_ADDR_W];
    end
  end

  // rd against the scoreboard catches WAW on an in-flight load
  always_comb begin
    w_hit = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (id_rs1_en[s] && w_busy[w_rs1[s]]) w_hit = 1'b1;
      if (id_rs2_en[s] && w_busy[w_rs2[s]]) w_hit = 1'b1;
      if (id_rd_en[s] && w_busy[w_rd[s]])   w_hit = 1'b1;
    end
    w_hit = w_hit & id_valid;
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = i + 1; j < NUM_SLOTS; j++) begin
        if (id_rd_en[i]) begin
          if (id_rs1_en[j] && w_rs1[j] == w_rd[i]) w_conflict = 1'b1;
          if (id_rs2_en[j] && w_rs2[j] == w_rd[i]) w_conflict = 1'b1;
          if (id_rd_en[j]  && w_rd[j]  == w_rd[i]) w_conflict = 1'b1;
        end
      end
    end
    w_conflict = w_conflict & id_valid;
  end

  assign w_flushing = branch_taken | (r_flush_cnt != '0);
  assign w_stall    = w_hit & ~w_flushing;
  assign w_issue    = id_valid & ~w_stall & ~w_flushing;

  always_comb begin
    w_set = '0;
    if (w_issue) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (id_is_load[s] && id_rd_en[s]) w_set[w_rd[s]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_mode = MODE_RUN;
    if (w_flushing)   w_mode = MODE_FLUSH;
    else if (w_stall) w_mode = MODE_STALL;
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    ctrl_mux    = 1'b1;
    if_id_flush = 1'b0;
    unique case (w_mode)
      MODE_STALL: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ctrl_mux    = 1'b0;
      end
      MODE_FLUSH: begin
        ctrl_mux    = 1'b0;
        if_id_flush = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar r = 0; r < NREG; r++) begin : g_ent
    hazard_sb_entry #(
      .LOAD_LAT(LOAD_LAT)
    ) u_ent (
      .clk   (clk),
      .rst   (rst),
      .i_set (w_set[r]),
      .o_busy(w_busy[r])
    );
  end

  // the branch cycle is the first flush cycle, hence BUBBLES-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else if (branch_taken) begin
      r_flush_cnt <= FW'(BRANCH_BUBBLES - 1);
    end else if (r_flush_cnt != '0) begin
      r_flush_cnt <= r_flush_cnt - FW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_conflict <= r_conflict | w_conflict;
      if (w_stall && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bundle_conflict = r_conflict;
  assign stall_cycles    = r_stall_cnt;

endmodule

// File: tb/tb_vliw_hazard_scoreboard.sv
// Randomized + directed bench; a queue-based scoreboard compares the
// DUT against a register-countdown reference model.
module tb_vliw_hazard_scoreboard;

  localparam int NS = 2;
  localparam int RW = 3;
  localparam int LL = 3;
  localparam int BB = 2;
  localparam int CW = 6;
  localparam int VW = NS * RW;

  typedef struct {
    logic          pcw;
    logic          ifw;
    logic          cm;
    logic          fl;
    logic          bc;
    logic [CW-1:0] sc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [VW-1:0] id_rs1 = '0;
  logic [VW-1:0] id_rs2 = '0;
  logic [VW-1:0] id_rd = '0;
  logic [NS-1:0] id_rs1_en = '0;
  logic [NS-1:0] id_rs2_en = '0;
  logic [NS-1:0] id_rd_en = '0;
  logic [NS-1:0] id_is_load = '0;
  logic          branch_taken = 1'b0;
  logic          pc_write;
  logic          if_id_write;
  logic          ctrl_mux;
  logic          if_id_flush;
  logic          bundle_conflict;
  logic [CW-1:0] stall_cycles;

  logic [VW-1:0] s_rs1, s_rs2, s_rd;
  logic [NS-1:0] s_rs1_en, s_rs2_en, s_rd_en, s_ld;

  int   m_pend [2**RW];
  int   m_flush;
  bit   m_conf;
  int   m_scnt;
  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  vliw_hazard_scoreboard #(
    .NUM_SLOTS(NS), .REG_ADDR_W(RW), .LOAD_LAT(LL),
    .BRANCH_BUBBLES(BB), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_rd_en(id_rd_en), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .pc_write(pc_write),
    .if_id_write(if_id_write), .ctrl_mux(ctrl_mux),
    .if_id_flush(if_id_flush),
    .bundle_conflict(bundle_conflict),
    .stall_cycles(stall_cycles)
  );

  task automatic clr();
    s_rs1 = '0; s_rs2 = '0; s_rd = '0;
    s_rs1_en = '0; s_rs2_en = '0; s_rd_en = '0; s_ld = '0;
  endtask

  task automatic set_slot(input int s, input int a1, input bit e1,
                          input int a2, input bit e2,
                          input int d, input bit de, input bit ld);
    s_rs1[s*RW +: RW] = a1[RW-1:0];
    s_rs2[s*RW +: RW] = a2[RW-1:0];
    s_rd[s*RW +: RW]  = d[RW-1:0];
    s_rs1_en[s] = e1;
    s_rs2_en[s] = e2;
    s_rd_en[s]  = de;
    s_ld[s]     = ld;
  endtask

  task automatic step(input bit v, input bit bt, input bit r);
    exp_t e;
    bit hit, fl, st, iss;
    int a1, a2, d, di;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; branch_taken = bt;
    id_rs1 = s_rs1; id_rs2 = s_rs2; id_rd = s_rd;
    id_rs1_en = s_rs1_en; id_rs2_en = s_rs2_en;
    id_rd_en = s_rd_en; id_is_load = s_ld;
    if (r) begin
      foreach (m_pend[k]) m_pend[k] = 0;
      m_flush = 0; m_conf = 0; m_scnt = 0;
    end
    hit = 0;
    for (int s = 0; s < NS; s++) begin
      a1 = int'(s_rs1[s*RW +: RW]);
      a2 = int'(s_rs2[s*RW +: RW]);
      d  = int'(s_rd[s*RW +: RW]);
      if (v && s_rs1_en[s] && m_pend[a1] > 0) hit = 1;
      if (v && s_rs2_en[s] && m_pend[a2] > 0) hit = 1;
      if (v && s_rd_en[s] && m_pend[d] > 0) hit = 1;
    end
    fl  = bt || (m_flush > 0);
    st  = hit && !fl;
    iss = v && !st && !fl;
    e.pcw = !st; e.ifw = !st; e.cm = !st && !fl; e.fl = fl;
    e.bc = m_conf; e.sc = CW'(m_scnt);
    q.push_back(e);
    if (!r) begin
      foreach (m_pend[k]) if (m_pend[k] > 0) m_pend[k]--;
      if (iss) begin
        for (int s = 0; s < NS; s++) begin
          if (s_ld[s] && s_rd_en[s]) m_pend[int'(s_rd[s*RW +: RW])] = LL;
        end
      end
      if (bt) m_flush = BB - 1;
      else if (m_flush > 0) m_flush--;
      for (int i = 0; i < NS; i++) begin
        di = int'(s_rd[i*RW +: RW]);
        for (int j = i + 1; j < NS; j++) begin
          if (v && s_rd_en[i]) begin
            if (s_rs1_en[j] && int'(s_rs1[j*RW +: RW]) == di) m_conf = 1;
            if (s_rs2_en[j] && int'(s_rs2[j*RW +: RW]) == di) m_conf = 1;
            if (s_rd_en[j] && int'(s_rd[j*RW +: RW]) == di) m_conf = 1;
          end
        end
      end
      if (st && m_scnt < (2**CW) - 1) m_scnt++;
    end
  endtask

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", n, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_write", int'(pc_write), int'(e.pcw));
        chk("if_id_write", int'(if_id_write), int'(e.ifw));
        chk("ctrl_mux", int'(ctrl_mux), int'(e.cm));
        chk("if_id_flush", int'(if_id_flush), int'(e.fl));
        chk("bundle_conflict", int'(bundle_conflict), int'(e.bc));
        chk("stall_cycles", int'(stall_cycles), int'(e.sc));
      end
    end
  end

  initial begin : driver
    clr();
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    // load r5, dependent reader held through its stall
    clr(); set_slot(0, 0, 0, 0, 0, 5, 1, 1); step(1, 0, 0);
    clr(); set_slot(1, 5, 1, 0, 0, 1, 1, 0);
    repeat (4) step(1, 0, 0);
    // load r5, unrelated reader of r2
    clr(); set_slot(0, 0, 0, 0, 0, 5, 1, 1); step(1, 0, 0);
    clr(); set_slot(1, 2, 1, 0, 0, 1, 1, 0); step(1, 0, 0);
    clr(); repeat (3) step(0, 0, 0);
    // branch pulse, then a branch inside the window
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    // hazard discarded by a simultaneous branch
    clr(); set_slot(0, 0, 0, 0, 0, 3, 1, 1); step(1, 0, 0);
    clr(); set_slot(0, 3, 1, 0, 0, 6, 1, 1); step(1, 1, 0);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    clr(); repeat (4) step(0, 0, 0);
    // intra-bundle RAW: sticky, no stall
    clr(); set_slot(0, 0, 0, 0, 0, 4, 1, 0);
    set_slot(1, 0, 0, 4, 1, 7, 1, 0); step(1, 0, 0);
    clr(); repeat (3) step(1, 0, 0);
    // reset with r3 pending and a flush window open
    clr(); set_slot(0, 0, 0, 0, 0, 3, 1, 1); step(1, 0, 0);
    clr(); step(0, 0, 0);
    step(0, 1, 0);
    set_slot(0, 3, 1, 0, 0, 0, 0, 0); step(1, 0, 1);
    step(1, 0, 0); step(1, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      s_rs1 = VW'($urandom); s_rs2 = VW'($urandom); s_rd = VW'($urandom);
      s_rs1_en = NS'($urandom); s_rs2_en = NS'($urandom);
      s_rd_en = NS'($urandom);
      for (int s = 0; s < NS; s++) s_ld[s] = ($urandom_range(2) == 0);
      step($urandom_range(9) != 0, $urandom_range(11) == 0,
           $urandom_range(299) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
